// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch front end: address/instruction types,
// RV32 control-transfer opcodes, the fetch FSM state encoding, the packet
// handed to the instruction buffer, and the default geometry of the fetch
// group and I-cache line.
package fetch_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] ADDR;
  typedef logic [31:0]     INST;

  localparam int  FETCH_W_DEFAULT    = 3;
  localparam int  LINE_INSTS_DEFAULT = 8;
  localparam ADDR RESET_PC_DEFAULT   = 32'h0000_0000;

  localparam logic [6:0] RV32_BRANCH  = 7'b1100011;
  localparam logic [6:0] RV32_JAL_OP  = 7'b1101111;
  localparam logic [6:0] RV32_JALR_OP = 7'b1100111;

  typedef enum logic {
    FS_RUN       = 1'b0,
    FS_MISS_WAIT = 1'b1
  } FETCH_STATE;

  // Predictor bookkeeping carried with each packet; fetch leaves it zeroed.
  typedef struct packed {
    logic [7:0] ghr;
    logic [1:0] ctr;
  } BP_PACKET;

  typedef struct packed {
    INST      inst;
    ADDR      PC;
    logic     taken;
    ADDR      predicted_PC;
    logic     is_jump;
    BP_PACKET bp_packet;
  } FETCH_PACKET;

  function automatic logic is_branch_op(input logic [6:0] opcode);
    return opcode == RV32_BRANCH;
  endfunction

  function automatic logic is_jump_op(input logic [6:0] opcode);
    return (opcode == RV32_JAL_OP) || (opcode == RV32_JALR_OP);
  endfunction

endpackage

// File: rtl/fetch_ctrl_group_len.sv
// Fetch group length: the number of leading slots that survive this cycle.
// The result is the minimum of four limits:
//   - slots before the first I-cache miss,
//   - slots up to and including the first predicted-taken transfer,
//   - slots left before the end of the current cache line,
//   - free instruction-buffer entries.
// Ports:
//   cache_hit  per-slot hit
//   taken      per-slot predicted-taken control transfer
//   line_idx   instruction index of slot 0 within its cache line
//   buf_spots  free instruction-buffer entries
//   count      surviving group length
//   miss_at_0  slot 0 missed (nothing can be delivered, miss wait needed)
module fetch_ctrl_group_len
  import fetch_ctrl_pkg::*;
#(
  parameter int FETCH_W    = FETCH_W_DEFAULT,
  parameter int LINE_INSTS = LINE_INSTS_DEFAULT,
  parameter int CNT_W      = $clog2(FETCH_W + 1),
  parameter int LINE_IDX_W = (LINE_INSTS > 1) ? $clog2(LINE_INSTS) : 1
) (
  input  logic [FETCH_W-1:0]    cache_hit,
  input  logic [FETCH_W-1:0]    taken,
  input  logic [LINE_IDX_W-1:0] line_idx,
  input  logic [CNT_W-1:0]      buf_spots,
  output logic [CNT_W-1:0]      count,
  output logic                  miss_at_0
);

  int miss_lim;
  int taken_lim;
  int line_lim;
  int lim;

  always_comb begin
    miss_lim  = FETCH_W;
    taken_lim = FETCH_W;
    // Scan from the top so the lowest matching slot wins.
    for (int i = FETCH_W - 1; i >= 0; i--) begin
      if (!cache_hit[i]) miss_lim = i;
      if (taken[i])      taken_lim = i + 1;
    end

    if (LINE_INSTS == 1) line_lim = 1;
    else                 line_lim = LINE_INSTS - int'(line_idx);

    lim = miss_lim;
    if (taken_lim < lim)       lim = taken_lim;
    if (line_lim < lim)        lim = line_lim;
    if (int'(buf_spots) < lim) lim = int'(buf_spots);

    count     = CNT_W'(lim);
    miss_at_0 = !cache_hit[0];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch controller. Each cycle it requests FETCH_W sequential PCs
// from the I-cache, keeps the leading slots that survive the miss / taken /
// line-end / buffer-space limits, packs them for the instruction buffer and
// steers the PC. A slot-0 miss parks the controller in MISS_WAIT until the
// refill arrives; a branch-stack restore overrides everything but reset.
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   fetch_req        I-cache request valid
//   fetch_pcs        requested PCs, slot i = PC + 4*i
//   cache_data       returned instructions (same cycle)
//   cache_hit        per-slot hit
//   refill_done      missed line now resident
//   restore_valid    redirect from the branch stack
//   restore_PC       redirect target
//   bp_taken         per-slot direction prediction
//   btb_hit          per-slot BTB hit
//   btb_target       per-slot BTB target
//   buf_spots        free instruction-buffer entries (saturated at FETCH_W)
//   out_packets      packets to the instruction buffer, low slots valid
//   out_count        number of valid packets
//   miss_cycles      cycles spent waiting for a refill (saturating)
//   stall_cycles     RUN cycles lost to buffer backpressure (saturating)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int  FETCH_W    = FETCH_W_DEFAULT,
  parameter int  LINE_INSTS = LINE_INSTS_DEFAULT,
  parameter ADDR RESET_PC   = RESET_PC_DEFAULT,
  parameter int  CNT_W      = $clog2(FETCH_W + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     fetch_req,
  output ADDR         [FETCH_W-1:0] fetch_pcs,
  input  INST         [FETCH_W-1:0] cache_data,
  input  logic        [FETCH_W-1:0] cache_hit,
  input  logic                     refill_done,
  input  logic                     restore_valid,
  input  ADDR                      restore_PC,
  input  logic        [FETCH_W-1:0] bp_taken,
  input  logic        [FETCH_W-1:0] btb_hit,
  input  ADDR         [FETCH_W-1:0] btb_target,
  input  logic        [CNT_W-1:0]   buf_spots,
  output FETCH_PACKET [FETCH_W-1:0] out_packets,
  output logic        [CNT_W-1:0]   out_count,
  output logic        [31:0]        miss_cycles,
  output logic        [31:0]        stall_cycles
);

  localparam int LINE_IDX_W = (LINE_INSTS > 1) ? $clog2(LINE_INSTS) : 1;

  FETCH_STATE          state;
  FETCH_STATE          state_nxt;
  ADDR                 pc_reg;
  ADDR                 pc_nxt;
  logic [FETCH_W-1:0]  is_br;
  logic [FETCH_W-1:0]  is_jmp;
  logic [FETCH_W-1:0]  taken;
  logic [CNT_W-1:0]    grp_count;
  logic                miss_at_0;
  logic                last_taken;
  ADDR                 last_target;
  logic                miss_evt;
  logic                stall_evt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      fetch_pcs[i] = pc_reg + ADDR'(4 * i);
      is_br[i]     = is_branch_op(cache_data[i][6:0]);
      is_jmp[i]    = is_jump_op(cache_data[i][6:0]);
      taken[i]     = btb_hit[i] & (is_jmp[i] | (is_br[i] & bp_taken[i]));
    end
  end

  fetch_ctrl_group_len #(
    .FETCH_W    (FETCH_W),
    .LINE_INSTS (LINE_INSTS),
    .CNT_W      (CNT_W),
    .LINE_IDX_W (LINE_IDX_W)
  ) u_group_len (
    .cache_hit (cache_hit),
    .taken     (taken),
    .line_idx  (pc_reg[2 +: LINE_IDX_W]),
    .buf_spots (buf_spots),
    .count     (grp_count),
    .miss_at_0 (miss_at_0)
  );

  always_comb begin
    fetch_req = !reset && (state == FS_RUN);

    out_count = '0;
    if (fetch_req && !restore_valid) out_count = grp_count;

    last_taken  = 1'b0;
    last_target = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      out_packets[i] = '0;
      if (i < int'(out_count)) begin
        out_packets[i].inst         = cache_data[i];
        out_packets[i].PC           = fetch_pcs[i];
        out_packets[i].taken        = taken[i];
        out_packets[i].predicted_PC = taken[i] ? btb_target[i] : fetch_pcs[i] + 32'd4;
        out_packets[i].is_jump      = is_jmp[i];
      end
      // A taken transfer can only ever be the last surviving slot.
      if ((int'(out_count) == i + 1) && taken[i]) begin
        last_taken  = 1'b1;
        last_target = btb_target[i];
      end
    end

    state_nxt = state;
    pc_nxt    = pc_reg;
    stall_evt = 1'b0;
    miss_evt  = (state == FS_MISS_WAIT);

    case (state)
      FS_RUN: begin
        if (restore_valid) begin
          pc_nxt = restore_PC;
        end else if (miss_at_0) begin
          state_nxt = FS_MISS_WAIT;
        end else begin
          pc_nxt    = last_taken ? last_target : pc_reg + (ADDR'(out_count) << 2);
          stall_evt = (out_count == '0);
        end
      end
      FS_MISS_WAIT: begin
        if (restore_valid) begin
          state_nxt = FS_RUN;
          pc_nxt    = restore_PC;
        end else if (refill_done) begin
          state_nxt = FS_RUN;
        end
      end
      default: state_nxt = FS_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= FS_RUN;
      pc_reg       <= RESET_PC;
      miss_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      state  <= state_nxt;
      pc_reg <= pc_nxt;
      if (miss_evt)  miss_cycles  <= sat_inc(miss_cycles);
      if (stall_evt) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Parametrised front-end fetch controller. Each cycle it issues up to FETCH_W sequential PCs to the I-cache and truncates the returned group at the first miss, the first predicted-taken control transfer, the cache-line boundary or the instruction-buffer free space. It forwards the surviving packets to the instruction buffer and steers the PC register. It adds three things to the previous fetch logic: a miss-wait FSM, line-boundary truncation, and stall/miss performance counters.

Parameters:
FETCH_W, 3, fetch group width (instructions per cycle); must be ≥1.
LINE_INSTS, 8, instructions per I-cache line; power of 2 and ≥ FETCH_W.
RESET_PC, 32'h0, PC loaded on reset.
CNT_W, $clog2(FETCH_W+1), width of the count buses.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fetch_req  out  1  I-cache request valid
fetch_pcs  out  FETCH_W x ADDR  PCs requested; slot i = PC_reg + 4*i
cache_data  in  FETCH_W x INST  I-cache data, same cycle as the request
cache_hit  in  FETCH_W  per-slot hit
refill_done  in  1  pulse: line for the missed PC is now resident
restore_valid  in  1  branch-stack redirect
restore_PC  in  ADDR  redirect target
bp_taken  in  FETCH_W  direction prediction per slot
btb_hit  in  FETCH_W  BTB hit per slot
btb_target  in  FETCH_W x ADDR  BTB target per slot
buf_spots  in  CNT_W  free instruction-buffer entries, saturated at FETCH_W
out_packets  out  FETCH_W x FETCH_PACKET  packets to the instruction buffer
out_count  out  CNT_W  number of valid packets, always low slots 0..out_count-1
miss_cycles  out  32  cycles spent in MISS_WAIT
stall_cycles  out  32  RUN cycles with out_count==0 and no miss

Behaviour:
- Reset
  - While reset is high: out_count=0 and fetch_req=0.
  - Next edge loads PC_reg=RESET_PC, state=RUN and both counters=0.
- FSM has two states: RUN and MISS_WAIT.
  - Combinational path: PCs to cache, cache to packets, all in one cycle; 0-cycle latency.
- Slot classification
  - is_branch: opcode == RV32_BRANCH.
  - is_jump: opcode is RV32_JAL_OP or RV32_JALR_OP.
  - taken[i] = btb_hit[i] & (is_jump[i] | (is_branch[i] & bp_taken[i])).
- Group length in RUN; out_count = min of:
  - (a) index of the first slot with cache_hit==0, or FETCH_W if none;
  - (b) index of the first taken slot + 1, or FETCH_W if none;
  - (c) LINE_INSTS - PC_reg[2 +: log2(LINE_INSTS)];
  - (d) buf_spots.
- Packet fields, slot i:
  - inst = cache_data[i];
  - PC = fetch_pcs[i];
  - taken = taken[i];
  - predicted_PC = taken ? btb_target[i] : PC+4;
  - is_jump = is_jump[i];
  - bp_packet is zero-filled.
  - Slots ≥ out_count are all-zero.
- Next PC in RUN
  - out_count>0 and taken[out_count-1]: btb_target[out_count-1].
  - Otherwise: PC_reg + 4*out_count.
  - Addition wraps modulo 2^32.
- Miss entry
  - If the limiting term is (a) with first miss at slot 0, then out_count=0.
  - Go to MISS_WAIT and hold PC_reg.
  - A miss at slot k>0 delivers slots 0..k-1, advances PC to slot k and stays in RUN.
- MISS_WAIT
  - fetch_req=0 and out_count=0; miss_cycles increments each cycle.
  - On refill_done, go to RUN next cycle and re-request the same PC.
- Redirect priority: restore_valid > reset-release > normal operation.
  - restore_valid in any state forces out_count=0 that cycle.
  - Next edge: PC_reg=restore_PC, state=RUN.
  - A refill_done arriving in RUN is ignored.
- Counters
  - stall_cycles increments when state==RUN, fetch_req=1, out_count==0, no slot-0 miss and no restore (backpressure).
  - Both counters saturate at 32'hFFFF_FFFF.
- fetch_req=1 in RUN whenever not in reset.

Decomposition:
- sys_defs gains FETCH_W, LINE_INSTS, RESET_PC defaults and a FETCH_STATE enum {FS_RUN, FS_MISS_WAIT}.
- FETCH_PACKET stays in sys_defs.
- One natural sub-module: fetch_group_len, the combinational min-of-limits plus first-taken/first-miss priority encoding.
- Reuse the existing psel_gen and encoder inside it.

Test Plan:
1. Reset, then PC=0, all hit, no branches, buf_spots=3 -> out_count=3, PCs 0/4/8, next PC=0xC.
2. PC=0x18, LINE_INSTS=8 -> line limit 2, out_count=2, next PC=0x20.
3. Slot 1 is BRANCH with bp_taken=1, btb_hit=1, target 0x100 -> out_count=2, packet[1].taken=1, next PC=0x100; same case with btb_hit=0 -> out_count=3, next PC=PC+12.
4. cache_hit=3'b110 at PC 0x40 -> MISS_WAIT, fetch_req=0 for 5 cycles, miss_cycles=5; refill_done -> RUN, fetch_pcs[0]=0x40 re-requested.
5. restore_valid with restore_PC=0x200 during MISS_WAIT and also in the same cycle as a taken branch -> out_count=0 that cycle, next PC=0x200, state RUN; a later refill_done is ignored.
6. buf_spots=0 for 4 cycles, all hit -> out_count=0, PC held, stall_cycles=4; reset mid-stall -> counters 0, PC=RESET_PC.
